// File: rtl/fsm_detector_pkg.sv
// rtl/fsm_detector_pkg.sv - constants and elaboration-time helpers for the serial pattern detector
package fsm_detector_pkg;

    localparam int MAX_LEN = 16;
    localparam int FW      = 5;

    typedef logic [FW-1:0] fail_arr_t [0:MAX_LEN];

    // Bit i in arrival order; the first bit received is the MSB of the pattern.
    function automatic logic pat_bit(input logic [MAX_LEN-1:0] pattern, input int len, input int i);
        return pattern[4'(len - 1 - i)];
    endfunction

    function automatic int calc_fail(input logic [MAX_LEN-1:0] pattern, input int len, input int k);
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < MAX_LEN; l++) begin
            if (l < k) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_LEN; j++) begin
                    if (j < l && pat_bit(pattern, len, j) != pat_bit(pattern, len, k - l + j)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = l;
                end
            end
        end
        return best;
    endfunction

    // From MATCH the search resumes at fail(N) or at S0, then falls back until b fits.
    function automatic int next_state(input logic [MAX_LEN-1:0] pattern, input int len,
                                      input logic overlap, input fail_arr_t fails,
                                      input int k, input logic b);
        int   j;
        int   nxt;
        logic done;
        j    = (k >= len) ? (overlap ? int'(fails[5'(len)]) : 0) : k;
        nxt  = 0;
        done = 1'b0;
        for (int i = 0; i <= MAX_LEN; i++) begin
            if (!done) begin
                if (b == pat_bit(pattern, len, j)) begin
                    nxt  = j + 1;
                    done = 1'b1;
                end else if (j == 0) begin
                    nxt  = 0;
                    done = 1'b1;
                end else begin
                    j = int'(fails[5'(j)]);
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fsm_detector.sv
// rtl/fsm_detector.sv - Moore serial pattern detector with KMP fallback
module fsm_detector
    import fsm_detector_pkg::*;
#(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1010,
    parameter bit                     OVERLAP     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic data,
    output logic out
);

    localparam int                 SW      = $clog2(PATTERN_LEN + 1);
    localparam logic [MAX_LEN-1:0] PAT_EXT = MAX_LEN'(PATTERN);

    if (PATTERN_LEN < 1 || PATTERN_LEN > MAX_LEN) begin : g_len_check
        $error("fsm_detector: PATTERN_LEN out of range 1..16");
    end

    logic [FW-1:0] fail_tbl [0:PATTERN_LEN];
    fail_arr_t     fail_arr;
    logic [SW-1:0] state;
    logic [SW-1:0] state_next;

    for (genvar g = 0; g <= MAX_LEN; g++) begin : g_fail
        if (g <= PATTERN_LEN) begin : g_used
            assign fail_tbl[g] = FW'(calc_fail(PAT_EXT, PATTERN_LEN, g));
            assign fail_arr[g] = fail_tbl[g];
        end else begin : g_pad
            assign fail_arr[g] = '0;
        end
    end

    always_comb begin
        state_next = '0;
        state_next = SW'(next_state(PAT_EXT, PATTERN_LEN, OVERLAP, fail_arr, int'(state), data));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else begin
            state <= state_next;
        end
    end

    assign out = (state == SW'(PATTERN_LEN));

endmodule

// File: tb/tb_fsm_detector.sv
// tb/tb_fsm_detector.sv - self-checking bench for fsm_detector across three configurations
module tb_fsm_detector;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic data  = 1'b0;
    logic out_def;
    logic out_nov;
    logic out_111;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    fsm_detector #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u_def (
        .clk(clk), .reset(reset), .data(data), .out(out_def));
    fsm_detector #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u_nov (
        .clk(clk), .reset(reset), .data(data), .out(out_nov));
    fsm_detector #(.PATTERN_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1)) u_111 (
        .clk(clk), .reset(reset), .data(data), .out(out_111));

    typedef struct {
        int          len;
        logic [15:0] bits;
        logic [15:0] e_def;
        logic [15:0] e_nov;
        logic [15:0] e_111;
    } vec_t;

    vec_t vecs [7];

    // Reference: keep the recent bits, a hit is simply "the last N bits equal the pattern".
    bit   hq   [3][$];
    bit   pseq [3][$];
    bit   movl [3];
    logic mdl  [3];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            hq[c].delete();
            mdl[c] = 1'b0;
        end
    endtask

    task automatic model_bit(input logic b);
        bit hit;
        for (int c = 0; c < 3; c++) begin
            hq[c].push_back(b);
            if (hq[c].size() > pseq[c].size()) void'(hq[c].pop_front());
            hit = (hq[c].size() == pseq[c].size());
            for (int j = 0; j < hq[c].size(); j++) begin
                if (hq[c][j] != pseq[c][j]) hit = 1'b0;
            end
            mdl[c] = hit;
            if (hit && !movl[c]) hq[c].delete();
        end
    endtask

    // Called between edges; returns 5 ns after the sampling edge.
    task automatic send(input logic b);
        @(negedge clk);
        data = b;
        @(posedge clk);
        #5;
        model_bit(b);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        data  = 1'b0;
        @(posedge clk);
        #5;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        pseq[0] = '{1, 0, 1, 0};  movl[0] = 1'b1;
        pseq[1] = '{1, 0, 1, 0};  movl[1] = 1'b0;
        pseq[2] = '{1, 1, 1};     movl[2] = 1'b1;
        model_clear();

        vecs[0] = '{8, 16'b10101010,  16'b00010101,  16'b00010001,  16'b00000000};
        vecs[1] = '{5, 16'b11010,     16'b00001,     16'b00001,     16'b00000};
        vecs[2] = '{8, 16'b11000011,  16'b0,         16'b0,         16'b0};
        vecs[3] = '{8, 16'b10000001,  16'b0,         16'b0,         16'b0};
        vecs[4] = '{6, 16'b111111,    16'b0,         16'b0,         16'b001111};
        vecs[5] = '{7, 16'b1110111,   16'b0,         16'b0,         16'b0010001};
        vecs[6] = '{9, 16'b101101010, 16'b000000101, 16'b000000100, 16'b0};

        #2;
        reset = 1'b1;
        #1;
        check("reset_out", out_def, 1'b0);
        check("reset_state", (u_def.state == '0), 1'b1);
        @(posedge clk);
        #5;
        reset = 1'b0;
        model_clear();

        for (int i = 0; i < 16; i++) begin
            send(1'b0);
            check("idle_def", out_def, 1'b0);
            check("idle_nov", out_nov, 1'b0);
            check("idle_111", out_111, 1'b0);
            check("idle_state", (u_def.state == '0), 1'b1);
        end

        for (int v = 0; v < 7; v++) begin
            apply_reset();
            for (int i = 0; i < vecs[v].len; i++) begin
                send(vecs[v].bits[4'(vecs[v].len - 1 - i)]);
                check($sformatf("vec%0d_bit%0d_def", v, i + 1), out_def, vecs[v].e_def[4'(vecs[v].len - 1 - i)]);
                check($sformatf("vec%0d_bit%0d_nov", v, i + 1), out_nov, vecs[v].e_nov[4'(vecs[v].len - 1 - i)]);
                check($sformatf("vec%0d_bit%0d_111", v, i + 1), out_111, vecs[v].e_111[4'(vecs[v].len - 1 - i)]);
            end
        end

        // Partial match 1,0,1 discarded by a mid-cycle reset.
        apply_reset();
        send(1'b1);
        send(1'b0);
        send(1'b1);
        check("mid_pre", out_def, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("mid_async_out", out_def, 1'b0);
        check("mid_async_state", (u_def.state == '0), 1'b1);
        reset = 1'b0;
        model_clear();
        send(1'b0);
        check("mid_after_0", out_def, 1'b0);
        send(1'b1);
        check("mid_seq_b1", out_def, 1'b0);
        send(1'b0);
        check("mid_seq_b2", out_def, 1'b0);
        send(1'b1);
        check("mid_seq_b3", out_def, 1'b0);
        send(1'b0);
        check("mid_seq_b4", out_def, 1'b1);

        // Reset while out is high must drop it without waiting for a clock.
        #2;
        reset = 1'b1;
        #1;
        check("drop_async_out", out_def, 1'b0);
        reset = 1'b0;
        model_clear();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset();
            end else begin
                send(1'($urandom_range(0, 1)));
                check("rand_def", out_def, mdl[0]);
                check("rand_nov", out_nov, mdl[1]);
                check("rand_111", out_111, mdl[2]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
